// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding and constants for the audio output path.
package audio_pkg;
   localparam int AUD_SAMPLE_W = 8;
   localparam int DEF_PRESCALER_MAX = 2;
   localparam int DEF_COUNTER_MAX = 255;
   localparam logic [AUD_SAMPLE_W-1:0] DEF_IDLE_LEVEL = 8'h80;
   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_PLAY, ST_DRAIN} aud_state_e;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous sample FIFO with occupancy count and flush.
module audio_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int W = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  data_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full_o  = level_q == LW'(DEPTH);
   assign empty_o = level_q == '0;
   assign level_o = level_q;
   assign data_o  = mem_q[rd_ptr_q];

   // flush overrides any concurrent push or pop
   always_comb begin
      do_push  = push_i && !full_o && !flush_i;
      do_pop   = pop_i && !empty_o && !flush_i;
      wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(do_push);
      rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(do_pop);
      level_d  = flush_i ? '0 : level_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/audio_pwm_stage.sv
// audio_pwm_stage: buffers PCM samples and plays one per PWM period,
// substituting an idle level and flagging underrun when the buffer runs dry.
module audio_pwm_stage
   import audio_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int PRIME_LEVEL = 4,
   parameter int PRESCALER_MAX = DEF_PRESCALER_MAX,
   parameter int COUNTER_MAX = DEF_COUNTER_MAX,
   parameter logic [AUD_SAMPLE_W-1:0] IDLE_LEVEL = DEF_IDLE_LEVEL,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_ni,
   input  logic                    enable_i,
   input  logic                    s_valid_i,
   input  logic [AUD_SAMPLE_W-1:0] s_data_i,
   output logic                    s_ready_o,
   output logic [LW-1:0]           level_o,
   output logic                    underrun_o,
   input  logic                    clr_underrun_i,
   output logic                    sample_tick_o,
   output logic                    aud_pwm,
   output logic                    aud_en
);
   localparam int PW = PRESCALER_MAX > 0 ? $clog2(PRESCALER_MAX + 1) : 1;
   // counter is at least sample-wide so the duty compare needs no truncation
   localparam int CW = COUNTER_MAX >= (1 << AUD_SAMPLE_W) ? $clog2(COUNTER_MAX + 1) : AUD_SAMPLE_W;

   aud_state_e              state_q, state_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic [CW-1:0]           count_q, count_d;
   logic [AUD_SAMPLE_W-1:0] value_q, value_d;
   logic                    underrun_q, underrun_d;
   logic                    tick_q, tick_d;
   logic                    pwm_q, pwm_d;
   logic                    fifo_pop, fifo_flush, fifo_full, fifo_empty, underrun_set;
   logic [AUD_SAMPLE_W-1:0] fifo_head;
   logic                    running, presc_wrap, count_wrap, period_end;

   assign running       = state_q == ST_PLAY || state_q == ST_DRAIN;
   assign presc_wrap    = presc_q == PW'(PRESCALER_MAX);
   assign count_wrap    = count_q == CW'(COUNTER_MAX);
   assign period_end    = presc_wrap && count_wrap;
   assign s_ready_o     = !fifo_full;
   assign underrun_o    = underrun_q;
   assign sample_tick_o = tick_q;
   assign aud_pwm       = pwm_q;
   assign aud_en        = running;

   audio_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(AUD_SAMPLE_W)) u_fifo (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .push_i  (s_valid_i && s_ready_o),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .data_i  (s_data_i),
      .data_o  (fifo_head),
      .level_o (level_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      presc_d      = '0;
      count_d      = '0;
      value_d      = value_q;
      tick_d       = 1'b0;
      fifo_pop     = 1'b0;
      fifo_flush   = 1'b0;
      underrun_set = 1'b0;
      if (running) begin
         presc_d = presc_wrap ? '0 : presc_q + PW'(1);
         count_d = presc_wrap ? (count_wrap ? '0 : count_q + CW'(1)) : count_q;
      end
      case (state_q)
         ST_IDLE: if (enable_i) state_d = ST_PRIME;
         ST_PRIME: begin
            if (!enable_i) state_d = ST_IDLE;
            else if (level_o >= LW'(PRIME_LEVEL)) begin
               state_d  = ST_PLAY;
               fifo_pop = 1'b1;
               value_d  = fifo_head;
               tick_d   = 1'b1;
            end
         end
         ST_PLAY: begin
            if (period_end) begin
               tick_d       = 1'b1;
               fifo_pop     = !fifo_empty;
               value_d      = fifo_empty ? IDLE_LEVEL : fifo_head;
               underrun_set = fifo_empty;
            end
            if (!enable_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (period_end) begin
               state_d    = ST_IDLE;
               fifo_flush = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      underrun_d = underrun_set || (underrun_q && !clr_underrun_i);
      pwm_d      = running && (CW'(value_q) >= count_q);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         count_q    <= '0;
         value_q    <= IDLE_LEVEL;
         underrun_q <= 1'b0;
         tick_q     <= 1'b0;
         pwm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         count_q    <= count_d;
         value_q    <= value_d;
         underrun_q <= underrun_d;
         tick_q     <= tick_d;
         pwm_q      <= pwm_d;
      end
   end
endmodule

// File: doc/audio_pwm_stage.md
Name: audio_pwm_stage

Overview:
- Downstream output stage of the audio path. Accepts 8-bit unsigned PCM samples over a valid/ready stream from the sample-fetch/player logic.
- Buffers samples in a small FIFO and emits one sample per PWM period on aud_pwm/aud_en.
- Decouples sample fetch (BRAM reads, SFX switching) from PWM timing. Reports FIFO underrun to software-visible status.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of two, 2..256.
- PRIME_LEVEL, 4, FIFO occupancy required before playback starts; 1..FIFO_DEPTH.
- PRESCALER_MAX, 2, clock divider terminal count; PWM counter advances every PRESCALER_MAX+1 clocks.
- COUNTER_MAX, 255, PWM counter terminal count; one period = (PRESCALER_MAX+1)*(COUNTER_MAX+1) clocks.
- IDLE_LEVEL, 8'h80, sample value substituted on underrun.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  playback request; level-sensitive.
- s_valid_i  in  1  upstream sample valid.
- s_data_i  in  8  upstream sample, unsigned.
- s_ready_o  out  1  FIFO can accept; equals !full.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun_o  out  1  sticky underrun flag.
- clr_underrun_i  in  1  clears underrun_o.
- sample_tick_o  out  1  one-cycle pulse when a sample is loaded into the PWM value register.
- aud_pwm  out  1  PWM audio output.
- aud_en  out  1  amplifier enable.

Behaviour:
- Reset (async assert, sync release): FIFO empty, level_o=0, s_ready_o=1, underrun_o=0, sample_tick_o=0, aud_pwm=0, aud_en=0, prescaler=0, counter=0, value=IDLE_LEVEL, state=IDLE.
- FIFO push when s_valid_i && s_ready_o.
- Push and pop in the same cycle: level unchanged, data order preserved.
- Pop happens only from the state machine. Pop on empty never corrupts pointers.
- Pointers wrap modulo FIFO_DEPTH. Full is level==FIFO_DEPTH.
- State machine: IDLE, PRIME, PLAY, DRAIN.
- IDLE:
  - aud_en=0, counters held at 0.
  - FIFO accepts pushes.
  - enable_i=1 -> PRIME.
- PRIME:
  - aud_en=0.
  - enable_i=0 -> IDLE.
  - level_o>=PRIME_LEVEL -> PLAY. On that transition, pop the head into value, pulse sample_tick_o, and clear prescaler and counter.
- PLAY:
  - aud_en=1.
  - prescaler counts 0..PRESCALER_MAX. On prescaler==PRESCALER_MAX, counter increments and wraps at COUNTER_MAX.
  - Period end is prescaler==PRESCALER_MAX && counter==COUNTER_MAX. At period end, pop the head into value and pulse sample_tick_o.
  - If the FIFO is empty at period end: value<=IDLE_LEVEL, underrun_o<=1, no pop, sample_tick_o still pulses, state stays PLAY.
  - enable_i=0 -> DRAIN.
- DRAIN:
  - The current period completes with aud_en=1 and no further pop.
  - At period end -> IDLE and flush the FIFO (level_o=0 next cycle).
  - enable_i reasserted during DRAIN is ignored until IDLE.
- aud_pwm = aud_en && (value >= counter), registered, so it lags the counter by one clock.
  - value=0 gives 1/(COUNTER_MAX+1) duty.
  - value>=COUNTER_MAX gives 100% duty.
- underrun_o:
  - Set and clear in the same cycle: set wins.
  - Cleared only by clr_underrun_i or reset, not by state changes.
- Reset asserted mid-period: all state returns to reset values immediately. Samples in flight are lost.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum (IDLE/PRIME/PLAY/DRAIN);
  - sample width constant AUD_SAMPLE_W=8;
  - default PRESCALER_MAX/COUNTER_MAX;
  - IDLE_LEVEL.
- One natural sub-module: audio_sample_fifo, a synchronous FIFO with push/pop/level/full/empty, reused by future mixer stages.

Test Plan:
- Reset mid-PLAY (PRESCALER_MAX=0, COUNTER_MAX=3, PRIME_LEVEL=2):
  - Stimulus: push 8'h02, 8'h03, enable_i=1, then pulse wb_rst_ni low mid-period.
  - Required: PLAY entered, value=2 then 3 each 4 clocks, aud_pwm high 3 of 4 clocks for value=2.
  - Required after reset pulse: aud_en=0, level_o=0, underrun_o=0 immediately.
- Underrun (same params):
  - Stimulus: push one sample 8'h01, PRIME_LEVEL=1, enable_i=1, no further pushes.
  - Required: after first period, value=8'h80, underrun_o=1, aud_en stays 1.
  - Required: clr_underrun_i pulse clears the flag, and the next period end sets it again.
- Full/backpressure (FIFO_DEPTH=16):
  - Stimulus: enable_i=0, drive s_valid_i continuously for 20 cycles.
  - Required: exactly 16 accepted, s_ready_o=0 and level_o=16 thereafter.
  - Required: simultaneous push+pop in PLAY keeps level_o constant.
- Drain (COUNTER_MAX=3):
  - Stimulus: deassert enable_i at counter=1 in PLAY.
  - Required: aud_en stays 1 through counter=3, then 0.
  - Required: level_o=0 one cycle after entering IDLE, and no sample_tick_o during DRAIN.
- Priming abort:
  - Stimulus: PRIME_LEVEL=4, push 3 samples, enable_i=1 for 10 cycles, then 0.
  - Required: state returns to IDLE, aud_en never asserts, level_o remains 3.
- Default timing:
  - Stimulus: PRESCALER_MAX=2, COUNTER_MAX=255, continuous supply.
  - Required: sample_tick_o period exactly 768 clocks, and each value V gives aud_pwm high V+1 counter steps per period.
